// File: rtl/cpu_multicycle_core.sv
// Multi-cycle CPU core: fetch/decode/execute/memory/writeback sequencer with a
// req/ack memory port, eight registers (r0 hardwired to zero) and NZCV flags.
module cpu_multicycle_core #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        flags,
    output logic              retire,
    output logic              halted,
    output logic              illegal
);
    localparam int unsigned MSB = DATA_W - 1;

    localparam logic [2:0] FETCH     = 3'd0;
    localparam logic [2:0] DECODE    = 3'd1;
    localparam logic [2:0] EXECUTE   = 3'd2;
    localparam logic [2:0] MEMORY    = 3'd3;
    localparam logic [2:0] WRITEBACK = 3'd4;
    localparam logic [2:0] HALT      = 3'd5;

    localparam logic [4:0] OP_NOP  = 5'h00;
    localparam logic [4:0] OP_ADD  = 5'h01;
    localparam logic [4:0] OP_SUB  = 5'h02;
    localparam logic [4:0] OP_AND  = 5'h03;
    localparam logic [4:0] OP_OR   = 5'h04;
    localparam logic [4:0] OP_XOR  = 5'h05;
    localparam logic [4:0] OP_ADDI = 5'h06;
    localparam logic [4:0] OP_LD   = 5'h07;
    localparam logic [4:0] OP_ST   = 5'h08;
    localparam logic [4:0] OP_BEQZ = 5'h09;
    localparam logic [4:0] OP_JMP  = 5'h0A;
    localparam logic [4:0] OP_HLT  = 5'h1F;

    logic [2:0]        state;
    logic              started;
    logic [ADDR_W-1:0] fetchPc;
    logic [ADDR_W-1:0] effAddr;
    logic [ADDR_W-1:0] ea;
    logic [4:0]        opcode;
    logic [2:0]        rd;
    logic [2:0]        rs1;
    logic [2:0]        rs2;
    logic [15:0]       imm;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic [DATA_W-1:0] opD;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] sextImm;
    logic [DATA_W-1:0] addend;
    logic [DATA_W-1:0] aluRes;
    logic [DATA_W:0]   wide;
    logic [3:0]        aluFlags;
    logic              ovf;
    logic              legalOp;
    logic [DATA_W-1:0] regs [8];

    // The first request waits for one edge after reset so mem_req starts low.
    assign mem_req   = (state == FETCH && started) || state == MEMORY;
    assign mem_we    = state == MEMORY && opcode == OP_ST;
    assign mem_addr  = (state == MEMORY) ? effAddr : (mem_req ? fetchPc : '0);
    assign mem_wdata = mem_we ? opD : '0;

    assign sextImm = {{(DATA_W - 16){imm[15]}}, imm};
    assign addend  = (opcode == OP_ADDI) ? sextImm : opB;
    assign ea      = opA[ADDR_W-1:0] + imm[ADDR_W-1:0];
    assign legalOp = opcode <= OP_JMP || opcode == OP_HLT;

    always_comb begin
        wide     = '0;
        aluRes   = '0;
        ovf      = 1'b0;
        aluFlags = flags;
        case (opcode)
            OP_ADD, OP_ADDI: begin
                wide     = {1'b0, opA} + {1'b0, addend};
                aluRes   = wide[MSB:0];
                ovf      = (opA[MSB] == addend[MSB]) && (aluRes[MSB] != opA[MSB]);
                aluFlags = {aluRes[MSB], aluRes == '0, wide[DATA_W], ovf};
            end
            OP_SUB: begin
                // Bit DATA_W of the widened difference is the unsigned borrow.
                wide     = {1'b0, opA} - {1'b0, opB};
                aluRes   = wide[MSB:0];
                ovf      = (opA[MSB] != opB[MSB]) && (aluRes[MSB] != opA[MSB]);
                aluFlags = {aluRes[MSB], aluRes == '0, wide[DATA_W], ovf};
            end
            OP_AND:  aluRes = opA & opB;
            OP_OR:   aluRes = opA | opB;
            OP_XOR:  aluRes = opA ^ opB;
            default: aluRes = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            started <= 1'b0;
            fetchPc <= RESET_PC;
            effAddr <= '0;
            pc      <= '0;
            opcode  <= '0;
            rd      <= '0;
            rs1     <= '0;
            rs2     <= '0;
            imm     <= '0;
            opA     <= '0;
            opB     <= '0;
            opD     <= '0;
            result  <= '0;
            flags   <= '0;
            retire  <= 1'b0;
            halted  <= 1'b0;
            illegal <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            retire <= 1'b0;
            case (state)
                FETCH: begin
                    if (!started) begin
                        started <= 1'b1;
                    end else if (mem_ack) begin
                        opcode  <= mem_rdata[31:27];
                        rd      <= mem_rdata[26:24];
                        rs1     <= mem_rdata[23:21];
                        rs2     <= mem_rdata[20:18];
                        imm     <= mem_rdata[15:0];
                        pc      <= fetchPc;
                        fetchPc <= fetchPc + ADDR_W'(1);
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    if (!legalOp) begin
                        state   <= HALT;
                        halted  <= 1'b1;
                        illegal <= 1'b1;
                    end else begin
                        opA   <= regs[rs1];
                        opB   <= regs[rs2];
                        opD   <= regs[rd];
                        state <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    flags <= aluFlags;
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: begin
                            result <= aluRes;
                            state  <= WRITEBACK;
                        end
                        OP_LD, OP_ST: begin
                            effAddr <= ea;
                            state   <= MEMORY;
                        end
                        OP_BEQZ: begin
                            if (opD == '0) fetchPc <= imm[ADDR_W-1:0];
                            state  <= FETCH;
                            retire <= 1'b1;
                        end
                        OP_JMP: begin
                            fetchPc <= imm[ADDR_W-1:0];
                            state   <= FETCH;
                            retire  <= 1'b1;
                        end
                        OP_HLT: begin
                            state  <= HALT;
                            halted <= 1'b1;
                            retire <= 1'b1;
                        end
                        OP_NOP: begin
                            state  <= FETCH;
                            retire <= 1'b1;
                        end
                        default: begin
                            state  <= FETCH;
                            retire <= 1'b1;
                        end
                    endcase
                end
                MEMORY: begin
                    if (mem_ack) begin
                        if (opcode == OP_LD) begin
                            result <= mem_rdata;
                            state  <= WRITEBACK;
                        end else begin
                            state  <= FETCH;
                            retire <= 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    if (rd != 3'd0) regs[rd] <= result;
                    state  <= FETCH;
                    retire <= 1'b1;
                end
                HALT:    state <= HALT;
                default: state <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_multicycle_core.sv
// Directed bench for cpu_multicycle_core: 32-bit core on a modelled req/ack memory,
// plus a 64-bit instance rerunning the basic arithmetic program.
module tb_cpu_multicycle_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        memReq, memWe, memAck = 1'b0;
    logic [15:0] memAddr, pcOut;
    logic [31:0] memWdata, memRdata = '0;
    logic [3:0]  flagsOut;
    logic        retire, halted, illegal;

    logic        reset64;
    logic        memReq64, memWe64, memAck64 = 1'b0;
    logic [15:0] memAddr64, pcOut64;
    logic [63:0] memWdata64, memRdata64 = '0;
    logic [3:0]  flagsOut64;
    logic        retire64, halted64, illegal64;

    cpu_multicycle_core #(.DATA_W(32), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .mem_req(memReq), .mem_we(memWe), .mem_addr(memAddr),
        .mem_wdata(memWdata), .mem_rdata(memRdata), .mem_ack(memAck), .pc(pcOut),
        .flags(flagsOut), .retire(retire), .halted(halted), .illegal(illegal)
    );

    cpu_multicycle_core #(.DATA_W(64), .ADDR_W(16), .RESET_PC(16'h0000)) dut64 (
        .clk(clk), .reset(reset64), .mem_req(memReq64), .mem_we(memWe64),
        .mem_addr(memAddr64), .mem_wdata(memWdata64), .mem_rdata(memRdata64),
        .mem_ack(memAck64), .pc(pcOut64), .flags(flagsOut64), .retire(retire64),
        .halted(halted64), .illegal(illegal64)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mem32 [0:65535];
    logic [31:0] mem64 [0:255];
    logic [31:0] wrMem [0:255];
    logic        wrValid [0:255];
    int          fetchDelay = 0;
    int          slowDelay = 0;
    logic [15:0] slowAddr = 16'h0010;
    int          waitCnt = 0;
    logic [15:0] readLog [$];
    int          retireAt [$];
    int          haltCycle;
    int          holdErrs;
    int          cnt;

    localparam logic [31:0] HLT = {5'h1F, 27'd0};

    // Memory model: ack decided on the falling edge for the next rising edge.
    always @(negedge clk) begin : memModel
        int d;
        if (!reset) begin
            readLog.delete();
            for (int i = 0; i < 256; i++) wrValid[i] = 1'b0;
        end
        if (memReq) begin
            d = (!memWe && memAddr == slowAddr) ? slowDelay : fetchDelay;
            if (waitCnt >= d) begin
                memAck  = 1'b1;
                waitCnt = 0;
                if (memWe) begin
                    if (memAddr < 16'd256) begin
                        wrMem[memAddr[7:0]]   = memWdata;
                        wrValid[memAddr[7:0]] = 1'b1;
                    end
                end else begin
                    if (memAddr < 16'd256 && wrValid[memAddr[7:0]])
                        memRdata = wrMem[memAddr[7:0]];
                    else
                        memRdata = mem32[memAddr];
                    readLog.push_back(memAddr);
                end
            end else begin
                memAck  = 1'b0;
                waitCnt = waitCnt + 1;
            end
        end else begin
            memAck  = 1'b0;
            waitCnt = 0;
        end
    end

    always @(negedge clk) begin
        memAck64 = memReq64;
        if (memReq64 && !memWe64) memRdata64 = {32'b0, mem64[memAddr64[7:0]]};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before 500us");
        $fatal(1);
    end

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2,
                                        input logic [15:0] imm);
        return {op, rd, rs1, rs2, 2'b00, imm};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic holdReset();
        @(negedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 65536; i++) mem32[i] = '0;
    endtask

    task automatic releaseReset();
        @(negedge clk); #1;
        reset = 1'b1;
        retireAt.delete();
    endtask

    task automatic run32(input string tag, input int maxCycles);
        int          firstReq = -1;
        logic        prevPending = 1'b0;
        logic [15:0] prevAddr = '0;
        logic        prevWe = 1'b0;
        holdErrs  = 0;
        haltCycle = -1;
        for (int k = 1; k <= maxCycles; k++) begin
            @(negedge clk); #1;
            if (memReq && firstReq < 0) firstReq = k;
            if (prevPending && (!memReq || memAddr !== prevAddr || memWe !== prevWe))
                holdErrs++;
            prevPending = memReq && !memAck;
            prevAddr    = memAddr;
            prevWe      = memWe;
            if (retire) retireAt.push_back(k - firstReq);
            if (halted) begin
                haltCycle = k - firstReq;
                break;
            end
        end
        check({tag, " halted"}, halted, 1'b1);
        check({tag, " request hold"}, holdErrs, 0);
    endtask

    task automatic loadProg1();
        mem32[0] = enc(5'h06, 3'd1, 3'd0, 3'd0, 16'd5);
        mem32[1] = enc(5'h06, 3'd2, 3'd0, 3'd0, 16'hFFFD);
        mem32[2] = enc(5'h01, 3'd3, 3'd1, 3'd2, 16'd0);
        mem32[3] = HLT;
    endtask

    initial begin
        reset   = 1'b1;
        reset64 = 1'b1;
        #2;
        reset   = 1'b0;
        reset64 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst mem_req", memReq, 1'b0);
        check("rst mem_we", memWe, 1'b0);
        check("rst mem_addr", memAddr, 16'h0);
        check("rst mem_wdata", memWdata, 32'h0);
        check("rst pc", pcOut, 16'h0);
        check("rst flags", flagsOut, 4'h0);
        check("rst retire", retire, 1'b0);
        check("rst halted", halted, 1'b0);
        check("rst illegal", illegal, 1'b0);

        // Scenario 1: ADDI/ADDI/ADD/HLT with zero-wait memory.
        holdReset();
        loadProg1();
        releaseReset();
        run32("s1", 60);
        check("s1 r1", dut.regs[1], 32'd5);
        check("s1 r2", dut.regs[2], 32'hFFFFFFFD);
        check("s1 r3", dut.regs[3], 32'd2);
        check("s1 flags", flagsOut, 4'b0010);
        check("s1 cycles", haltCycle, 15);
        check("s1 retires", retireAt.size(), 4);
        check("s1 retire0", retireAt[0], 4);
        check("s1 retire1", retireAt[1], 8);
        check("s1 retire2", retireAt[2], 12);
        check("s1 retire3", retireAt[3], 15);
        check("s1 pc", pcOut, 16'd3);
        check("s1 illegal", illegal, 1'b0);

        // Scenario 2a: 0 - 1 borrows and goes negative.
        holdReset();
        mem32[0] = enc(5'h06, 3'd2, 3'd0, 3'd0, 16'd1);
        mem32[1] = enc(5'h02, 3'd1, 3'd0, 3'd2, 16'd0);
        mem32[2] = HLT;
        releaseReset();
        run32("s2a", 60);
        check("s2a r1", dut.regs[1], 32'hFFFFFFFF);
        check("s2a flags", flagsOut, 4'b1010);

        // Scenario 2b: 7FFFFFFF + 1 overflows.
        holdReset();
        mem32[0]     = enc(5'h07, 3'd5, 3'd0, 3'd0, 16'h0040);
        mem32[16'h40] = 32'h7FFFFFFF;
        mem32[1]     = enc(5'h06, 3'd6, 3'd0, 3'd0, 16'd1);
        mem32[2]     = enc(5'h01, 3'd7, 3'd5, 3'd6, 16'd0);
        mem32[3]     = HLT;
        releaseReset();
        run32("s2b", 60);
        check("s2b r5", dut.regs[5], 32'h7FFFFFFF);
        check("s2b r7", dut.regs[7], 32'h80000000);
        check("s2b flags", flagsOut, 4'b1001);
        check("s2b cycles", haltCycle, 16);

        // Scenario 3: store then load with three wait states on the load.
        holdReset();
        slowDelay = 3;
        mem32[0] = enc(5'h06, 3'd1, 3'd0, 3'd0, 16'h00A5);
        mem32[1] = enc(5'h08, 3'd1, 3'd0, 3'd0, 16'h0010);
        mem32[2] = enc(5'h07, 3'd4, 3'd0, 3'd0, 16'h0010);
        mem32[3] = HLT;
        releaseReset();
        run32("s3", 80);
        slowDelay = 0;
        check("s3 stored", wrMem[16], 32'hA5);
        check("s3 r4", dut.regs[4], 32'hA5);
        check("s3 st cycles", retireAt[1] - retireAt[0], 4);
        check("s3 ld cycles", retireAt[2] - retireAt[1], 8);
        check("s3 cycles", haltCycle, 19);

        // Scenario 4: taken and untaken BEQZ.
        holdReset();
        mem32[0]      = enc(5'h09, 3'd0, 3'd0, 3'd0, 16'h0020);
        mem32[16'h20] = enc(5'h06, 3'd1, 3'd0, 3'd0, 16'd1);
        mem32[16'h21] = enc(5'h09, 3'd1, 3'd0, 3'd0, 16'h0030);
        mem32[16'h22] = HLT;
        mem32[16'h30] = enc(5'h15, 3'd0, 3'd0, 3'd0, 16'd0);
        releaseReset();
        run32("s4", 60);
        check("s4 fetches", readLog.size(), 4);
        check("s4 fetch1", readLog[1], 16'h0020);
        check("s4 fetch2", readLog[2], 16'h0021);
        check("s4 fetch3", readLog[3], 16'h0022);
        check("s4 illegal", illegal, 1'b0);
        check("s4 pc", pcOut, 16'h0022);

        // Scenario 4b: sequential wrap 0xFFFF -> 0x0000.
        holdReset();
        mem32[0]        = enc(5'h09, 3'd1, 3'd0, 3'd0, 16'hFFFF);
        mem32[16'hFFFF] = enc(5'h06, 3'd1, 3'd0, 3'd0, 16'd1);
        mem32[1]        = HLT;
        releaseReset();
        run32("s4b", 60);
        check("s4b fetches", readLog.size(), 4);
        check("s4b fetch1", readLog[1], 16'hFFFF);
        check("s4b fetch2", readLog[2], 16'h0000);
        check("s4b fetch3", readLog[3], 16'h0001);

        // Scenario 4c: JMP located at 0xFFFF back to 0.
        holdReset();
        mem32[0]        = enc(5'h09, 3'd1, 3'd0, 3'd0, 16'h0010);
        mem32[16'h10]   = enc(5'h06, 3'd1, 3'd0, 3'd0, 16'd1);
        mem32[16'h11]   = enc(5'h0A, 3'd0, 3'd0, 3'd0, 16'hFFFF);
        mem32[16'hFFFF] = enc(5'h0A, 3'd0, 3'd0, 3'd0, 16'h0000);
        mem32[1]        = HLT;
        releaseReset();
        run32("s4c", 80);
        check("s4c fetches", readLog.size(), 6);
        check("s4c fetch3", readLog[3], 16'hFFFF);
        check("s4c fetch4", readLog[4], 16'h0000);
        check("s4c fetch5", readLog[5], 16'h0001);

        // Scenario 5: r0 write discarded, then an undefined opcode.
        holdReset();
        mem32[0] = enc(5'h06, 3'd0, 3'd0, 3'd0, 16'd9);
        mem32[1] = enc(5'h06, 3'd1, 3'd0, 3'd0, 16'd3);
        mem32[2] = enc(5'h15, 3'd2, 3'd1, 3'd1, 16'd0);
        mem32[3] = enc(5'h06, 3'd2, 3'd0, 3'd0, 16'd4);
        releaseReset();
        run32("s5", 60);
        check("s5 illegal", illegal, 1'b1);
        check("s5 r0", dut.regs[0], 32'd0);
        check("s5 r1", dut.regs[1], 32'd3);
        check("s5 r2", dut.regs[2], 32'd0);
        check("s5 pc", pcOut, 16'd2);
        check("s5 cycles", haltCycle, 10);
        check("s5 retires", retireAt.size(), 2);
        cnt = 0;
        repeat (8) begin
            @(negedge clk); #1;
            if (memReq) cnt++;
        end
        check("s5 req in halt", cnt, 0);
        check("s5 fetches", readLog.size(), 3);

        // Scenario 6: reset asserted while a fetch is waiting.
        holdReset();
        loadProg1();
        fetchDelay = 6;
        releaseReset();
        repeat (3) @(negedge clk);
        #1;
        check("s6 req pending", memReq, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("s6 req dropped", memReq, 1'b0);
        check("s6 addr dropped", memAddr, 16'h0);
        fetchDelay = 0;
        releaseReset();
        run32("s6", 60);
        check("s6 first fetch", readLog[0], 16'h0000);
        check("s6 r3", dut.regs[3], 32'd2);
        check("s6 cycles", haltCycle, 15);

        // Scenario 7: 64-bit core on program 1.
        mem64[0] = enc(5'h06, 3'd1, 3'd0, 3'd0, 16'd5);
        mem64[1] = enc(5'h06, 3'd2, 3'd0, 3'd0, 16'hFFFD);
        mem64[2] = enc(5'h01, 3'd3, 3'd1, 3'd2, 16'd0);
        mem64[3] = HLT;
        @(negedge clk); #1;
        reset64 = 1'b1;
        cnt = 0;
        for (int k = 0; k < 60 && !halted64; k++) begin
            @(negedge clk); #1;
            if (retire64) cnt++;
        end
        check("s7 halted", halted64, 1'b1);
        check("s7 r2", dut64.regs[2], 64'hFFFFFFFFFFFFFFFD);
        check("s7 r3", dut64.regs[3], 64'd2);
        check("s7 flags", flagsOut64, 4'b0010);
        check("s7 retires", cnt, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
